alu_ctrl: RTL

Sequencing stage wrapped around the 12-bit combinational ALU. It accepts 9-bit register-to-register instructions over a valid/ready handshake and fetches operands from a local 4×12-bit register file. It drives registered operands and opcode into the ALU, captures the ALU result and flags, and writes the result back. It also exposes each completed result and its flag set to downstream logic.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcodes, instruction field layout and FSM states for the ALU sequencer.
package alu_pkg;

  localparam int ALU_W    = 12;
  localparam int ALU_NREG = 4;

  localparam logic [2:0] OP_SHR = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_ADD = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  // Instruction word: [8:6] op, [5:4] rd, [3:2] ra, [1:0] rb
  localparam int INSTR_W = 9;
  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 4;
  localparam int RA_LSB  = 2;
  localparam int RB_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // {C,S,V,Z}; carry and overflow are only meaningful for ADD
  function automatic logic [3:0] flags_of(input logic [2:0] op,
                                          input logic [ALU_W-1:0] z,
                                          input logic cout,
                                          input logic ov);
    logic is_add;
    is_add = (op == OP_ADD);
    return {cout & is_add, z[ALU_W-1], ov & is_add, ~|z};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x W register file: two async read ports, a write-back port and a load port.
// Write-back beats a load to the same index; loads to other indices land in the same cycle.
module alu_regfile #(
  parameter int W    = 12,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we && waddr == AW'(i))
          regs[i] <= wdata;
        else if (ld_en && ld_addr == AW'(i))
          regs[i] <= ld_data;
      end
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_ctrl.sv
// Sequences one register-to-register instruction through the external ALU: accept, FETCH, EXEC, WB (result at accept+3).
// Accepts only in IDLE or WB, so back-to-back throughput is one instruction per 3 cycles; a held instr_valid is never dropped.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int W    = ALU_W,
  parameter int NREG = ALU_NREG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ld_en,
  input  logic [1:0]         ld_addr,
  input  logic [W-1:0]       ld_data,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [2:0]         alu_op,
  input  logic [W-1:0]       alu_z,
  input  logic               alu_cout,
  input  logic               alu_sign,
  input  logic               alu_ov,
  output logic               res_valid,
  output logic [W-1:0]       res_data,
  output logic [3:0]         res_flags,
  output logic               busy
);

  localparam int AW = $clog2(NREG);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic [2:0]         op_q;
  logic [AW-1:0]      rd_q, ra_q, rb_q;
  logic [W-1:0]       rdata_a, rdata_b;
  logic               accept;
  logic               unused_sign;

  // Sign is taken from the captured result itself, not from the ALU's sign output
  assign unused_sign = alu_sign;

  assign op_q   = instr_q[OP_LSB +: 3];
  assign rd_q   = instr_q[RD_LSB +: AW];
  assign ra_q   = instr_q[RA_LSB +: AW];
  assign rb_q   = instr_q[RB_LSB +: AW];
  assign accept = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WB;
      ST_WB:    state_nxt = accept ? ST_FETCH : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    res_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_WB: begin
        instr_ready = 1'b1;
        res_valid   = 1'b1;
      end
      default: ;
    endcase
  end

  // res_data/res_flags are the EXEC holding registers: loaded on entry to WB, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_data  <= '0;
      res_flags <= '0;
    end else begin
      if (accept) instr_q <= instr;
      if (state == ST_FETCH) begin
        alu_a  <= rdata_a;
        alu_b  <= rdata_b;
        alu_op <= op_q;
      end
      if (state == ST_EXEC) begin
        res_data  <= alu_z;
        res_flags <= flags_of(alu_op, alu_z, alu_cout, alu_ov);
      end
    end
  end

  alu_regfile #(
    .W    (W),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (state == ST_WB),
    .waddr   (rd_q),
    .wdata   (res_data),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .raddr_a (ra_q),
    .rdata_a (rdata_a),
    .raddr_b (rb_q),
    .rdata_b (rdata_b)
  );

endmodule
